// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable RV32 data memory with byte/half/word
// loads and stores, sign/zero extension and fault detection. Requests use a
// valid/ready handshake followed by a programmable number of wait states.
// After every reset a sequential engine clears the array before the first
// request is accepted.
module data_memory_lsu #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [IDX_W-1:0]      INIT_LAST = IDX_W'(MEM_DEPTH - 1);
  localparam logic [IDX_W-1:0]      CNT_ONE   = IDX_W'(1'b1);
  localparam logic [3:0]            WS_LOAD   = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-3:0] DEPTH_LIM = (DATA_WIDTH-2)'(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_W    = {DATA_WIDTH{1'b0}};

  // Fault rules: reserved size, misaligned half/word, or word index past the array.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [DATA_WIDTH-1:0] addr);
    logic bad_align;
    logic bad_range;
    case (size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = addr[0];
      2'b10:   bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    bad_range = (addr[DATA_WIDTH-1:2] >= DEPTH_LIM);
    return bad_align | bad_range;
  endfunction

  // Merge right-aligned store data into the addressed lanes of the old word.
  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] wdata,
                                                        input logic [1:0] size,
                                                        input logic [1:0] lane);
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] data;
    case (size)
      2'b00: begin
        mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {lane, 3'b000};
        data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
        data = {{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << {lane[1], 4'b0000};
      end
      2'b10: begin
        mask = {DATA_WIDTH{1'b1}};
        data = wdata;
      end
      default: begin
        mask = ZERO_W;
        data = ZERO_W;
      end
    endcase
    return (old_word & ~mask) | (data & mask);
  endfunction

  // Pick the addressed lanes out of a word and sign- or zero-extend them.
  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [1:0] size,
                                                         input logic [1:0] lane,
                                                         input logic uns);
    logic [DATA_WIDTH-1:0] sh_b;
    logic [DATA_WIDTH-1:0] sh_h;
    logic [DATA_WIDTH-1:0] res;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (size)
      2'b00: res = uns ? {{(DATA_WIDTH-8){1'b0}}, sh_b[7:0]}
                       : {{(DATA_WIDTH-8){sh_b[7]}}, sh_b[7:0]};
      2'b01: res = uns ? {{(DATA_WIDTH-16){1'b0}}, sh_h[15:0]}
                       : {{(DATA_WIDTH-16){sh_h[15]}}, sh_h[15:0]};
      2'b10: res = word;
      default: res = ZERO_W;
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  logic [1:0]            state_r;
  logic [IDX_W-1:0]      init_cnt_r;
  logic                  init_arm_r;
  logic                  init_done_r;
  logic [3:0]            wcnt_r;
  logic                  op_we_r;
  logic [1:0]            op_size_r;
  logic                  op_uns_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_wd_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rd_r;
  logic                  rsp_err_r;

  logic                  accept_s;
  logic                  access_s;
  logic                  op_we_s;
  logic [1:0]            op_size_s;
  logic                  op_uns_s;
  logic [DATA_WIDTH-1:0] op_a_s;
  logic [DATA_WIDTH-1:0] op_wd_s;
  logic [IDX_W-1:0]      op_idx_s;
  logic                  fault_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rsp_rd_s;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  assign req_ready = (state_r == ST_IDLE) && en;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_r;
  assign RD        = rd_r;
  assign rsp_err   = rsp_err_r;
  assign init_done = init_done_r;

  // Operand source: live request while idle (zero-wait access), latched copy otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_we_s   = req_we;
      op_size_s = req_size;
      op_uns_s  = req_unsigned;
      op_a_s    = A;
      op_wd_s   = WD;
    end else begin
      op_we_s   = op_we_r;
      op_size_s = op_size_r;
      op_uns_s  = op_uns_r;
      op_a_s    = op_a_r;
      op_wd_s   = op_wd_r;
    end
  end

  // Decide whether the coming edge is the access edge.
  always_comb begin
    access_s = 1'b0;
    case (state_r)
      ST_IDLE: access_s = accept_s && (WAIT_STATES == 32'sd0);
      ST_WAIT: access_s = (wcnt_r == 4'd1);
      default: access_s = 1'b0;
    endcase
  end

  assign op_idx_s  = op_a_s[IDX_W+1:2];
  assign fault_s   = access_fault(op_size_s, op_a_s);
  assign rd_word_s = mem_r[op_idx_s];
  assign rsp_rd_s  = (fault_s || op_we_s) ? ZERO_W
                     : load_extract(rd_word_s, op_size_s, op_a_s[1:0], op_uns_s);

  // Array write port: init-engine clear has priority over committed stores.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = op_idx_s;
    mem_wdata_s = ZERO_W;
    if ((state_r == ST_INIT) && init_arm_r) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = init_cnt_r;
      mem_wdata_s = ZERO_W;
    end else if (access_s && op_we_s && !fault_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = op_idx_s;
      mem_wdata_s = store_merge(rd_word_s, op_wd_s, op_size_s, op_a_s[1:0]);
    end else begin
      mem_we_s    = 1'b0;
      mem_widx_s  = op_idx_s;
      mem_wdata_s = ZERO_W;
    end
  end

  // Storage array; contents are cleared by the init engine, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Control FSM: init sweep, handshake, wait countdown and one-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {IDX_W{1'b0}};
      init_arm_r  <= 1'b0;
      init_done_r <= 1'b0;
      wcnt_r      <= 4'd0;
      op_we_r     <= 1'b0;
      op_size_r   <= 2'b00;
      op_uns_r    <= 1'b0;
      op_a_r      <= ZERO_W;
      op_wd_r     <= ZERO_W;
      rsp_valid_r <= 1'b0;
      rd_r        <= ZERO_W;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          // The first edge after reset arms the sweep; each later edge clears one word.
          if (!init_arm_r) begin
            init_arm_r <= 1'b1;
          end else if (init_cnt_r == INIT_LAST) begin
            init_arm_r  <= 1'b0;
            init_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            init_cnt_r <= init_cnt_r + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            op_we_r   <= req_we;
            op_size_r <= req_size;
            op_uns_r  <= req_unsigned;
            op_a_r    <= A;
            op_wd_r   <= WD;
            if (access_s) begin
              rsp_valid_r <= 1'b1;
              rd_r        <= rsp_rd_s;
              rsp_err_r   <= fault_s;
              state_r     <= ST_RESP;
            end else begin
              wcnt_r  <= WS_LOAD;
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (access_s) begin
            rsp_valid_r <= 1'b1;
            rd_r        <= rsp_rd_s;
            rsp_err_r   <= fault_s;
            state_r     <= ST_RESP;
          end else begin
            wcnt_r <= wcnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          rd_r        <= ZERO_W;
          rsp_err_r   <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu (MEM_DEPTH=16, WAIT_STATES=2).
// The reference model is a flat byte array driven by the access rules.
module tb_data_memory_lsu;

  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] WD = 32'h0;
  logic        rsp_valid;
  logic [31:0] RD;
  logic        rsp_err;
  logic        init_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem [DEPTH*4];

  data_memory_lsu #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
    .rsp_valid(rsp_valid), .RD(RD), .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic ref_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference access from the rules: fault check, then byte-level store or load.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output logic exp_err);
    int n;
    logic [31:0] v;
    exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    exp_rd = 32'h0;
    if (!exp_err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!uns && n < 4 && v[8*n-1]) begin
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        exp_rd = v;
      end
    end
  endtask

  // Driver: wait for ready, present one request, observe the response window.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic err_o,
                        output int lat_o, output int pulses_o);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; A = addr; WD = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat_o = -1; pulses_o = 0; rd_o = 32'h0; err_o = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid === 1'b1) begin
        pulses_o++;
        if (lat_o < 0) begin
          lat_o = k; rd_o = RD; err_o = rsp_err;
        end
      end
    end
    if (guard >= 100) lat_o = -2;
  endtask

  // Release reset and count edges until init_done; returns rise edge and violations.
  task automatic wait_init(output int rise, output logic early_ready, output logic saw_rsp);
    rise = -1; early_ready = 1'b0; saw_rsp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 40 && rise < 0; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
      if (init_done === 1'b1) rise = i;
      else if (req_ready !== 1'b0) early_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    int rise; logic early, saw; logic [31:0] rd; logic err; int lat, pl;
    ref_clear();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, RD, rsp_err, init_done} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b v=%b rd=%h err=%b done=%b, want all 0",
               req_ready, rsp_valid, RD, rsp_err, init_done);
    end
    wait_init(rise, early, saw);
    tests_run++;
    if (rise !== DEPTH + 1) begin
      tests_failed++;
      $display("FAIL init_latency: init_done rose at edge %0d, want %0d", rise, DEPTH + 1);
    end
    tests_run++;
    if (early !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_ready: early=%b ready=%b, want early=0 ready=1", early, req_ready);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0 || lat !== WS + 1 || pl !== 1) begin
      tests_failed++;
      $display("FAIL lw_after_init: rd=%h err=%b lat=%0d pulses=%0d, want 0 0 %0d 1", rd, err, lat, pl, WS + 1);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, er; logic err, ee; int lat, pl;
    ref_access(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, er, ee);
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0 || lat !== 3 || pl !== 1) begin
      tests_failed++;
      $display("FAIL sw_resp: rd=%h err=%b lat=%0d pulses=%0d, want 0 0 3 1", rd, err, lat, pl);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat !== 3 || pl !== 1) begin
      tests_failed++;
      $display("FAIL lw_readback: rd=%h err=%b lat=%0d pulses=%0d, want deadbeef 0 3 1", rd, err, lat, pl);
    end
  endtask

  task automatic test_subword();
    logic [1:0]  sz [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h8, 32'hB, 32'hB, 32'hA, 32'hA};
    logic [31:0] ex [5] = '{32'hDEAD12EF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
    logic [31:0] rd, er; logic err, ee; int lat, pl;
    ref_access(1'b1, 2'b00, 1'b0, 32'h9, 32'h00000012, er, ee);
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h00000012, rd, err, lat, pl);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rd, err, lat, pl);
      tests_run++;
      if (rd !== ex[i] || err !== 1'b0 || lat !== 3) begin
        tests_failed++;
        $display("FAIL subword_%0d: rd=%h err=%b lat=%0d, want %h 0 3", i, rd, err, lat, ex[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h6, 32'h9, 32'h0, 32'h40};
    logic [31:0] rd; logic err; int lat, pl;
    for (int i = 0; i < 4; i++) begin
      do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, rd, err, lat, pl);
      tests_run++;
      if (rd !== 32'h0 || err !== 1'b1 || lat !== 3 || pl !== 1) begin
        tests_failed++;
        $display("FAIL fault_%0d: rd=%h err=%b lat=%0d, want 0 1 3", i, rd, err, lat);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_lw0: rd=%h err=%b, want 0 0", rd, err);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'hDEAD12EF || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_nowrite: rd=%h err=%b, want dead12ef 0", rd, err);
    end
  endtask

  task automatic test_random();
    logic we, uns, err, ee; logic [1:0] sz; logic [31:0] ad, wd, rd, er; int lat, pl;
    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      ad  = 32'($urandom_range(0, 79));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) ad = ad & ~((32'h1 << sz) - 32'h1);
      wd  = $urandom;
      ref_access(we, sz, uns, ad, wd, er, ee);
      do_req(we, sz, uns, ad, wd, rd, err, lat, pl);
      tests_run++;
      if (rd !== er || err !== ee || lat !== 3 || pl !== 1) begin
        tests_failed++;
        $display("FAIL random_%0d we=%b sz=%0d u=%b a=%h: rd=%h err=%b lat=%0d pl=%0d, want %h %b 3 1",
                 i, we, sz, uns, ad, rd, err, lat, pl, er, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc [$]; int pulses; logic bad;
    pulses = 0; bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; A = 32'h0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready === 1'b1) acc.push_back(c);
      if (rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != WS + 2) bad = 1'b1;
    tests_run++;
    if (acc.size() != 4 || bad || pulses != acc.size()) begin
      tests_failed++;
      $display("FAIL back_to_back: accepts=%0d spacing_bad=%b pulses=%0d, want 4 0 4", acc.size(), bad, pulses);
    end
  endtask

  task automatic test_enable();
    logic bad; int lat; logic [31:0] rd, er; logic ee;
    bad = 1'b0; lat = -1; rd = 32'h0;
    ref_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, er, ee);
    @(negedge clk);
    en = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; A = 32'h8;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL enable_gate: ready or response seen with en=0, want none");
    end
    en = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL enable_ready: ready=%b, want 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid === 1'b1 && lat < 0) begin
        lat = k; rd = RD;
      end
    end
    en = 1'b1;
    tests_run++;
    if (lat !== 3 || rd !== er) begin
      tests_failed++;
      $display("FAIL enable_resp: lat=%0d rd=%h, want 3 %h", lat, rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int rise; logic early, saw; logic [31:0] rd; logic err; int lat, pl;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; A = 32'h4; WD = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if (init_done !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: done=%b v=%b rdy=%b, want 0 0 0", init_done, rsp_valid, req_ready);
    end
    ref_clear();
    wait_init(rise, early, saw);
    tests_run++;
    if (rise !== DEPTH + 1 || saw !== 1'b0 || early !== 1'b0) begin
      tests_failed++;
      $display("FAIL reinit: rise=%0d rsp_seen=%b early=%b, want %0d 0 0", rise, saw, early, DEPTH + 1);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0 || lat !== 3) begin
      tests_failed++;
      $display("FAIL dropped_store: rd=%h err=%b lat=%0d, want 0 0 3", rd, err, lat);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, err, lat, pl);
    tests_run++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL recleared: rd=%h err=%b, want 0 0", rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_faults();
    test_random();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Parametrised byte-addressable data memory for the RV32 datapath. It executes byte, halfword and word loads and stores with sign/zero extension. It detects misaligned, oversized and out-of-range accesses, models a configurable number of wait states behind a valid/ready handshake, and zeroes its array with a sequential init engine after reset. It sits between the execute stage and the writeback mux.

## Interface
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words; must be at least 2.
- WAIT_STATES, 1, extra cycles between accept and access; range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  block enable; gates request acceptance only.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) && en.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_unsigned  in  1  zero-extend byte/half loads; ignored for word and stores.
- A  in  DATA_WIDTH  byte address.
- WD  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- RD  out  DATA_WIDTH  extended load data; 0 whenever rsp_valid=0, for stores, and on error.
- rsp_err  out  1  access faulted; valid only with rsp_valid.
- init_done  out  1  array clear complete.

## Operation
- States: INIT, IDLE, WAIT, RESP.
- Reset (rst=1) forces state INIT, init counter 0, and all outputs 0 (req_ready, rsp_valid, RD, rsp_err, init_done).
- INIT: writes zero to word[cnt] each cycle, cnt 0..MEM_DEPTH-1. After the write of word MEM_DEPTH-1, the block goes to IDLE and init_done=1, which holds until the next reset. Requests are ignored during INIT.
- IDLE: when req_valid && req_ready on an edge, the block registers we/size/unsigned/A/WD.
  - Goes to WAIT if WAIT_STATES>0, else directly to access.
- WAIT: a down-counter loaded with WAIT_STATES. The access happens on the edge where it reaches its last cycle.
- Access, a single edge entering RESP:
  - Index = A[31:2]; lane = A[1:0].
  - Fault if any of: size==11; size==01 && A[0]; size==10 && A[1:0]!=0; index >= MEM_DEPTH.
  - Fault: no write, RD=0, rsp_err=1.
  - Store SB: WD[7:0] to lane. SH: WD[15:0] to lanes {A[1],0}. SW: full word. Other lanes unchanged (read-modify-write of the word).
  - Load: extracts lane bytes and sign-extends, or zero-extends if req_unsigned. RD=0 for stores.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. RD and rsp_err return to 0 with rsp_valid.
- en=0 during WAIT/RESP does not abort the in-flight operation.
- Reset mid-operation aborts it:
  - A store not yet committed is dropped.
  - No rsp_valid is issued.
  - The array is re-cleared.

## Timing
- Init: init_done rises MEM_DEPTH cycles after the first edge with rst=0.
- Load/store latency: rsp_valid is high in the (WAIT_STATES+1)-th cycle after the accept edge.
- Throughput: one request per WAIT_STATES+2 cycles.
- req_ready is low in WAIT and RESP. A new request is accepted no earlier than the edge ending the first IDLE cycle after RESP.
- Store visibility: a store commits on the access edge, so a following load sees the new data.
- rst assertion takes effect immediately, without waiting for clk. Deassertion is followed by INIT at the next edge.

## Test plan
All scenarios use MEM_DEPTH=16, WAIT_STATES=2.
- Reset release -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1. LW 0x0 -> RD=0x00000000, rsp_err=0.
- SW 0x8 0xDEADBEEF, then LW 0x8 -> RD=0xDEADBEEF. rsp_valid is high exactly in the 3rd cycle after each accept edge, for 1 cycle.
- Subword accesses after SB 0x9 WD=0x00000012:
  - LW 0x8 -> 0xDEAD12EF.
  - LB 0xB -> 0xFFFFFFDE.
  - LBU 0xB -> 0x000000DE.
  - LH 0xA -> 0xFFFFDEAD.
  - LHU 0xA -> 0x0000DEAD.
- Faults:
  - LW 0x6, SH 0x9, size=11 at 0x0, and SW 0x40 -> each rsp_err=1, RD=0.
  - LW 0x0 afterwards still returns 0.
- SW 0x4 0x55AA55AA, rst pulsed during WAIT -> no rsp_valid, re-init of 16 cycles. LW 0x4 -> 0x00000000.
- en=0 with req_valid=1 in IDLE -> req_ready=0, no response for 10 cycles. en=1 -> accepted on the next edge, response 3 cycles later.
